vga_timing_gen: RTL and testbench

//  Parametrised raster timing generator for the VGA display path; successor to the fixed 640x480 sync block.

---
 rtl/vga_pkg.sv | 32 +++
 rtl/vga_tick_div.sv | 29 ++
 rtl/vga_timing_gen.sv | 112 +++++++++++
 tb/tb_vga_timing_gen.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared timing descriptors for the VGA raster path: per-axis timing record,
// the 640x480@60 preset and a width helper.
package vga_pkg;

    typedef struct packed {
        int unsigned display;
        int unsigned front;
        int unsigned sync;
        int unsigned back;
        int unsigned total;
    } vga_timing_t;

    function automatic vga_timing_t make_timing(input int unsigned d, input int unsigned f,
                                                input int unsigned s, input int unsigned b);
        vga_timing_t t;
        t.display = d;
        t.front   = f;
        t.sync    = s;
        t.back    = b;
        t.total   = d + f + s + b;
        return t;
    endfunction

    // Bits needed to hold values 0..maxval (never less than one bit).
    function automatic int width_for(input int maxval);
        return (maxval < 1) ? 1 : $clog2(maxval + 1);
    endfunction

    localparam vga_timing_t VGA_640X480_H = make_timing(640, 16, 96, 48);
    localparam vga_timing_t VGA_640X480_V = make_timing(480, 10, 2, 33);

endpackage

// File: rtl/vga_tick_div.sv
// Pixel-clock divider: one-clk tick every CLK_DIV enabled system clocks.
module vga_tick_div
    import vga_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int DW = width_for(CLK_DIV - 1);
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div;

    // With CLK_DIV = 1, LAST is 0, div never leaves 0 and tick follows enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            div <= '0;
        end else if (enable) begin
            div <= (div == LAST) ? '0 : div + 1'b1;
        end
    end

    assign tick = enable && (div == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel divider, h/v counters and a
// single output register stage so every output is mutually aligned.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int H_DISPLAY = VGA_640X480_H.display,
    parameter int H_FRONT   = VGA_640X480_H.front,
    parameter int H_SYNC    = VGA_640X480_H.sync,
    parameter int H_BACK    = VGA_640X480_H.back,
    parameter int V_DISPLAY = VGA_640X480_V.display,
    parameter int V_FRONT   = VGA_640X480_V.front,
    parameter int V_SYNC    = VGA_640X480_V.sync,
    parameter int V_BACK    = VGA_640X480_V.back,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int CNT_W     = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic             pixel_tick,
    output logic             h_sync,
    output logic             v_sync,
    output logic             video_on,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             line_start,
    output logic             frame_start
);

    localparam vga_timing_t HT = make_timing(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam vga_timing_t VT = make_timing(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(HT.total - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(VT.total - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(HT.display);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(VT.display);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(HT.display + HT.front);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(HT.display + HT.front + HT.sync - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(VT.display + VT.front);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(VT.display + VT.front + VT.sync - 1);

    logic             tick;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             hs_act;
    logic             vs_act;
    logic             vis;
    logic             at_origin_x;
    logic             at_origin_xy;

    vga_tick_div #(
        .CLK_DIV(CLK_DIV)
    ) u_div (
        .clk   (clk),
        .reset (reset),
        .enable(enable),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (tick) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        vis          = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        hs_act       = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
        vs_act       = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
        // Strobes fire only when the registered coordinate actually moves onto the origin,
        // which keeps them quiet straight out of reset and across enable gaps.
        at_origin_x  = (h_cnt == '0) && (pixel_x != '0);
        at_origin_xy = (h_cnt == '0) && (v_cnt == '0) && ((pixel_x != '0) || (pixel_y != '0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pixel_tick  <= 1'b0;
            h_sync      <= ~HS_POL;
            v_sync      <= ~VS_POL;
            video_on    <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (enable) begin
            pixel_tick  <= tick;
            h_sync      <= hs_act ? HS_POL : ~HS_POL;
            v_sync      <= vs_act ? VS_POL : ~VS_POL;
            video_on    <= vis;
            pixel_x     <= h_cnt;
            pixel_y     <= v_cnt;
            line_start  <= at_origin_x;
            frame_start <= at_origin_xy;
        end else begin
            pixel_tick  <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a small fast-wrapping config and the default 640x480
// config, both checked every clock against an arithmetic tick-count model.
module tb_vga_timing_gen;

    logic       clk = 1'b0;
    logic [1:0] rst = 2'b11;
    logic [1:0] en  = 2'b11;

    // index 0: small config, index 1: defaults
    logic       pt_s, hs_s, vs_s, von_s, ls_s, fs_s;
    logic [3:0] x_s, y_s;
    logic       pt_d, hs_d, vs_d, von_d, ls_d, fs_d;
    logic [9:0] x_d, y_d;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .CLK_DIV(1), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(4)
    ) dut_s (
        .clk(clk), .reset(rst[0]), .enable(en[0]), .pixel_tick(pt_s), .h_sync(hs_s),
        .v_sync(vs_s), .video_on(von_s), .pixel_x(x_s), .pixel_y(y_s),
        .line_start(ls_s), .frame_start(fs_s)
    );

    vga_timing_gen dut_d (
        .clk(clk), .reset(rst[1]), .enable(en[1]), .pixel_tick(pt_d), .h_sync(hs_d),
        .v_sync(vs_d), .video_on(von_d), .pixel_x(x_d), .pixel_y(y_d),
        .line_start(ls_d), .frame_start(fs_d)
    );

    typedef struct {
        int tick, hs, vs, von, x, y, ls, fs;
    } exp_t;

    int n_chk  = 0;
    int n_fail = 0;
    int n[2]   = '{0, 0};   // enabled clocks since last reset
    bit held[2] = '{1'b0, 1'b0};

    int fs_cnt_s, ls_cnt_s, fs_first_s, fs_gap_s;
    int hs_low_d, ls_cnt_d, fs_cnt_d;

    // Expected outputs after the n-th enabled clock since reset; the counters hold
    // floor(k/cdiv) ticks after k enabled clocks and outputs trail them by one clock.
    function automatic exp_t model(input int cnt, input bit hld, input int cd,
                                   input int hd, input int hf, input int hsw, input int hb,
                                   input int vd, input int vf, input int vsw, input int vb,
                                   input int hp, input int vp);
        exp_t m;
        int ht, vt, t, tp, h, v;
        ht = hd + hf + hsw + hb;
        vt = vd + vf + vsw + vb;
        m = '{tick: 0, hs: 1 - hp, vs: 1 - vp, von: 0, x: 0, y: 0, ls: 0, fs: 0};
        if (cnt == 0) return m;
        t  = (cnt - 1) / cd;
        tp = (cnt >= 2) ? (cnt - 2) / cd : 0;
        h  = t % ht;
        v  = (t / ht) % vt;
        m.x   = h;
        m.y   = v;
        m.von = (h < hd && v < vd) ? 1 : 0;
        m.hs  = (h >= hd + hf && h < hd + hf + hsw) ? hp : 1 - hp;
        m.vs  = (v >= vd + vf && v < vd + vf + vsw) ? vp : 1 - vp;
        if (!hld) begin
            m.tick = (((cnt - 1) % cd) == cd - 1) ? 1 : 0;
            m.ls   = (cnt >= 2 && t != tp && h == 0) ? 1 : 0;
            m.fs   = (m.ls == 1 && v == 0) ? 1 : 0;
        end
        return m;
    endfunction

    function automatic exp_t exp_s();
        return model(n[0], held[0], 1, 8, 2, 3, 1, 4, 1, 1, 1, 1, 1);
    endfunction

    function automatic exp_t exp_d();
        return model(n[1], held[1], 2, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    task automatic check_all();
        exp_t e;
        e = exp_s();
        chk("s.pixel_tick",  32'(pt_s),  32'(e.tick));
        chk("s.h_sync",      32'(hs_s),  32'(e.hs));
        chk("s.v_sync",      32'(vs_s),  32'(e.vs));
        chk("s.video_on",    32'(von_s), 32'(e.von));
        chk("s.pixel_x",     32'(x_s),   32'(e.x));
        chk("s.pixel_y",     32'(y_s),   32'(e.y));
        chk("s.line_start",  32'(ls_s),  32'(e.ls));
        chk("s.frame_start", 32'(fs_s),  32'(e.fs));
        e = exp_d();
        chk("d.pixel_tick",  32'(pt_d),  32'(e.tick));
        chk("d.h_sync",      32'(hs_d),  32'(e.hs));
        chk("d.v_sync",      32'(vs_d),  32'(e.vs));
        chk("d.video_on",    32'(von_d), 32'(e.von));
        chk("d.pixel_x",     32'(x_d),   32'(e.x));
        chk("d.pixel_y",     32'(y_d),   32'(e.y));
        chk("d.line_start",  32'(ls_d),  32'(e.ls));
        chk("d.frame_start", 32'(fs_d),  32'(e.fs));
    endtask

    task automatic step();
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (rst[i]) begin
                n[i] = 0;
                held[i] = 1'b0;
            end else if (en[i]) begin
                n[i]++;
                held[i] = 1'b0;
            end else begin
                held[i] = 1'b1;
            end
        end
        #1;
        check_all();
        if (fs_s) begin
            if (fs_cnt_s == 0) fs_first_s = n[0];
            else if (fs_cnt_s == 1) fs_gap_s = n[0] - fs_first_s;
            fs_cnt_s++;
            chk("s.line_with_frame", 32'(ls_s), 32'd1);
        end
        if (ls_s) ls_cnt_s++;
        if (!hs_d && !rst[1] && en[1]) hs_low_d++;
        if (ls_d) ls_cnt_d++;
        if (fs_d) fs_cnt_d++;
    endtask

    initial begin
        int held_x, guard;
        fs_cnt_s = 0; ls_cnt_s = 0; fs_first_s = 0; fs_gap_s = 0;
        hs_low_d = 0; ls_cnt_d = 0; fs_cnt_d = 0;

        // reset overrides enable
        rst = 2'b11; en = 2'b11;
        step(); step();
        rst = 2'b00;

        // two full frames of the small config: wrap 13->0, 6->0 on one clock
        repeat (197) step();
        chk("s.frame_count", 32'(fs_cnt_s), 32'd2);
        chk("s.frame_period", 32'(fs_gap_s), 32'd98);
        chk("s.line_count", 32'(ls_cnt_s), 32'd14);

        // randomised enable gaps and occasional resets on the small config
        repeat (400) begin
            en[0]  = ($urandom_range(0, 3) != 0);
            rst[0] = ($urandom_range(0, 63) == 0);
            step();
        end
        rst[0] = 1'b0; en[0] = 1'b1;

        // first default line incl. the whole h_sync pulse: 96 ticks = 192 clk low
        guard = 0;
        while (n[1] < 1700 && guard < 3000) begin step(); guard++; end
        chk("d.reach_1700", 32'(n[1]), 32'd1700);
        chk("d.hsync_low_clks", 32'(hs_low_d), 32'd192);

        // enable low 50 clk mid-line: everything frozen
        held_x = int'(x_d);
        en[1] = 1'b0;
        repeat (50) step();
        chk("d.frozen_x", 32'(x_d), 32'(held_x));
        en[1] = 1'b1;
        repeat (3) step();

        // run to pixel_x = 300, then a single-clock reset
        guard = 0;
        while (exp_d().x != 300 && guard < 2000) begin step(); guard++; end
        chk("d.reach_x300", 32'(x_d), 32'd300);
        rst[1] = 1'b1;
        step();
        rst[1] = 1'b0;
        chk("d.rst_x", 32'(x_d), 32'd0);
        chk("d.rst_y", 32'(y_d), 32'd0);
        chk("d.rst_video_on", 32'(von_d), 32'd0);
        chk("d.rst_hsync", 32'(hs_d), 32'd1);
        chk("d.rst_vsync", 32'(vs_d), 32'd1);
        ls_cnt_d = 0; fs_cnt_d = 0;
        repeat (1700) step();
        chk("d.lines_after_rst", 32'(ls_cnt_d), 32'd1);
        chk("d.frames_after_rst", 32'(fs_cnt_d), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
